fwd_select_reg: RTL and testbench
=================================

// Module: fwd_select_reg
// PURPOSE
//   Registered, parametrised operand-source selector for the pipelined CPU datapath.
//   Selects one register operand from the register file or from NUM_SRC forwarding sources
//   (EX/MEM/WB results) by destination-address match, in fixed priority order.
//   Detects load-use hazards and drives the selected operand into the ID/EX boundary register.
//   Supports stall, flush and a saturating forward-hit counter.
// PARAMETERS
//   WIDTH    32  operand data width
//   ADDR_W   5   register address width
//   NUM_SRC  3   forwarding sources, 1..7; index 0 is the youngest stage and has highest priority
//   ZERO_REG 1   1: address 0 is never forwarded and always yields rf_data
//   CNT_W    16  forward-hit counter width
//   SEL_W (localparam) = clog2(NUM_SRC+1)
// PORTS
//   clk          in   1              rising-edge clock
//   reset        in   1              synchronous, active-high reset
//   in_valid     in   1              an operand request is present this cycle
//   in_addr      in   ADDR_W         source register address of the request
//   rf_data      in   WIDTH          register-file read data for in_addr
//   src_en       in   NUM_SRC        source k writes a register
//   src_addr     in   NUM_SRC*ADDR_W source k destination address; slice k = [k*ADDR_W +: ADDR_W]
//   src_data     in   NUM_SRC*WIDTH  source k result; slice k = [k*WIDTH +: WIDTH]
//   src_pending  in   NUM_SRC        source k result is not yet available (e.g. a load in EX)
//   stall        in   1              hold the output register
//   flush        in   1              kill the output register contents
//   out_valid    out  1              registered: out_data is a valid operand
//   out_data     out  WIDTH          registered selected operand
//   out_src      out  SEL_W          registered: 0 = register file, k+1 = source k
//   stall_req    out  1              combinational: load-use hazard, upstream must stall
//   fwd_count    out  CNT_W          count of captured operands with out_src != 0
// BEHAVIOUR
//   - Match rule: match[k] = src_en[k] && src_addr[k] == in_addr && !(ZERO_REG && in_addr == 0).
//   - Winner: the lowest k with match[k] is selected.
//   - With no match: sel = 0 and data = rf_data.
//   - Otherwise: sel = k+1 and data = src_data[k].
//   - hazard = in_valid && winner exists && src_pending[winner].
//     - A pending lower-priority source is ignored when a higher-priority source matches.
//   - stall_req = hazard. It is purely combinational, has no registered dependency,
//     and is asserted even while stall or flush is high.
//   - Register update priority per clk edge: reset > flush > stall > capture.
//   - reset: out_valid=0, out_data=0, out_src=0, fwd_count=0.
//   - flush: out_valid=0, out_data=0, out_src=0; fwd_count holds.
//   - stall (no flush): every register holds, including fwd_count.
//   - capture (no stall, no flush):
//     - out_valid <= in_valid && !hazard.
//     - When in_valid && !hazard: out_data <= data and out_src <= sel.
//       If sel != 0, fwd_count increments, saturating at all-ones.
//     - Otherwise (bubble): out_data and out_src hold their previous values.
//   - Latency: exactly 1 cycle from request to out_*.
//   - Reset asserted mid-stall or mid-hazard: reset wins, and outputs are clean the next cycle.
//   - Widths: no arithmetic on data; fwd_count wraps never (saturates).
// TESTING
//   1 reset=1 for 2 cycles, then idle -> out_valid=0, out_data=0, out_src=0, fwd_count=0.
//   2 in_addr=5, rf_data=0x11, src_en=3'b000 -> next cycle out_data=0x11, out_src=0,
//     fwd_count=0.
//   3 in_addr=5; src0 addr=5, data=0xAA; src2 addr=5, data=0xCC; en=3'b101
//     -> out_data=0xAA, out_src=1, fwd_count=1.
//   4 in_addr=0, src0 addr=0, data=0xFF, en=1, rf_data=0 -> out_data=0, out_src=0,
//     fwd_count unchanged.
//   5 in_addr=7; src0 addr=7, pending=1; src1 addr=7 -> stall_req=1 same cycle,
//     next cycle out_valid=0 and out_data held. Then pending=0 -> out_data=src0 data,
//     out_src=1.
//   6 valid capture, then stall=1 for 3 cycles, then flush=1 with stall=1
//     -> outputs hold during the stall; after the flush out_valid=0 and out_data=0.
//     Separately, CNT_W=2 with 5 forwarded captures -> fwd_count=3 (saturated).

Source files
------------

// File: rtl/fwd_select_reg.sv
// ---------------------------------------------------------------------------
// fwd_select_reg
//   Registered operand-source selector for the ID/EX boundary of the pipeline.
//   One register operand is taken either from the register file or from one
//   of NUM_SRC forwarding sources (youngest stage first, index 0 = highest
//   priority) by destination-address match.  A load-use hazard is flagged
//   combinationally when the winning source's result is still pending.
//   The selected operand is captured into the output register unless the
//   stage is stalled or flushed.  A saturating counter tracks captured
//   operands that came from a forwarding source.
//
// Parameters
//   WIDTH    operand data width
//   ADDR_W   register address width
//   NUM_SRC  forwarding sources (1..7), index 0 has highest priority
//   ZERO_REG 1: address 0 is never forwarded and always yields rf_data
//   CNT_W    forward-hit counter width
//
// Ports
//   clk, reset    rising-edge clock, synchronous active-high reset
//   in_valid      operand request present this cycle
//   in_addr       source register address of the request
//   rf_data       register-file read data for in_addr
//   src_en        per-source write enable
//   src_addr      per-source destination address, slice k = [k*ADDR_W +: ADDR_W]
//   src_data      per-source result, slice k = [k*WIDTH +: WIDTH]
//   src_pending   per-source "result not yet available"
//   stall         hold every output register
//   flush         clear the output register (counter holds)
//   out_valid     registered: out_data is a valid operand
//   out_data      registered selected operand
//   out_src       registered: 0 = register file, k+1 = source k
//   stall_req     combinational load-use hazard
//   fwd_count     saturating count of captured forwarded operands
// ---------------------------------------------------------------------------
module fwd_select_reg #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_SRC  = 3,
    parameter bit          ZERO_REG = 1'b1,
    parameter int unsigned CNT_W    = 16,
    localparam int unsigned SEL_W   = $clog2(NUM_SRC + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [ADDR_W-1:0]         in_addr,
    input  logic [WIDTH-1:0]          rf_data,
    input  logic [NUM_SRC-1:0]        src_en,
    input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
    input  logic [NUM_SRC*WIDTH-1:0]  src_data,
    input  logic [NUM_SRC-1:0]        src_pending,
    input  logic                      stall,
    input  logic                      flush,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_src,
    output logic                      stall_req,
    output logic [CNT_W-1:0]          fwd_count
);

    logic [NUM_SRC-1:0] match;
    logic               addr_is_zero;
    logic               found;
    logic               win_pending;
    logic [SEL_W-1:0]   sel;
    logic [WIDTH-1:0]   data;
    logic               hazard;
    logic               accept;

    assign addr_is_zero = (in_addr == '0);

    // Address match per source; register 0 is excluded when ZERO_REG is set.
    always_comb begin
        match = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            match[k] = src_en[k]
                    && (src_addr[k*ADDR_W +: ADDR_W] == in_addr)
                    && !(ZERO_REG && addr_is_zero);
        end
    end

    // Fixed-priority pick: the first (lowest-index) matching source wins, and
    // only the winner's pending flag can raise a hazard.
    always_comb begin
        found       = 1'b0;
        win_pending = 1'b0;
        sel         = '0;
        data        = rf_data;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (match[k] && !found) begin
                found       = 1'b1;
                win_pending = src_pending[k];
                sel         = SEL_W'(k + 1);
                data        = src_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign hazard    = in_valid && found && win_pending;
    assign stall_req = hazard;
    assign accept    = in_valid && !hazard;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            fwd_count <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (!stall) begin
            out_valid <= accept;
            // A bubble leaves the previous operand and source in place.
            if (accept) begin
                out_data <= data;
                out_src  <= sel;
                if ((sel != '0) && (fwd_count != '1)) begin
                    fwd_count <= fwd_count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fwd_select_reg.sv
module tb_fwd_select_reg;

    localparam int W = 32;
    localparam int A = 5;
    localparam int N = 3;
    localparam int S = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic [A-1:0]   in_addr;
    logic [W-1:0]   rf_data;
    logic [N-1:0]   src_en;
    logic [N*A-1:0] src_addr;
    logic [N*W-1:0] src_data;
    logic [N-1:0]   src_pending;
    logic           stall;
    logic           flush;

    logic           out_valid, out_valid2;
    logic [W-1:0]   out_data, out_data2;
    logic [S-1:0]   out_src, out_src2;
    logic           stall_req, stall_req2;
    logic [15:0]    fwd_count;
    logic [1:0]     fwd_count2;

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic [S-1:0] s;
        logic [15:0]  c;
        logic [1:0]   c2;
    } exp_t;

    exp_t exp_q[$];
    exp_t m;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fwd_select_reg #(.WIDTH(W), .ADDR_W(A), .NUM_SRC(N), .ZERO_REG(1'b1), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_addr(in_addr), .rf_data(rf_data),
        .src_en(src_en), .src_addr(src_addr), .src_data(src_data), .src_pending(src_pending),
        .stall(stall), .flush(flush), .out_valid(out_valid), .out_data(out_data),
        .out_src(out_src), .stall_req(stall_req), .fwd_count(fwd_count)
    );

    fwd_select_reg #(.WIDTH(W), .ADDR_W(A), .NUM_SRC(N), .ZERO_REG(1'b1), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_addr(in_addr), .rf_data(rf_data),
        .src_en(src_en), .src_addr(src_addr), .src_data(src_data), .src_pending(src_pending),
        .stall(stall), .flush(flush), .out_valid(out_valid2), .out_data(out_data2),
        .out_src(out_src2), .stall_req(stall_req2), .fwd_count(fwd_count2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference selection: scan from lowest priority upward so the last hit
    // (lowest index) overwrites the others.
    task automatic ref_select(output logic [S-1:0] sel, output logic [W-1:0] d, output logic hz);
        sel = '0;
        d   = rf_data;
        hz  = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (src_en[k] && src_addr[k*A +: A] == in_addr && in_addr != 0) begin
                sel = S'(k + 1);
                d   = src_data[k*W +: W];
                hz  = in_valid && src_pending[k];
            end
        end
    endtask

    // Inputs are set just after a negedge; this checks the combinational
    // hazard, advances the model, and compares outputs after the posedge.
    task automatic cyc(input string tag);
        logic [S-1:0] sel;
        logic [W-1:0] d;
        logic         hz;
        exp_t         e;
        #1;
        ref_select(sel, d, hz);
        check({tag, ".stall_req"}, stall_req, hz);
        check({tag, ".stall_req2"}, stall_req2, hz);
        if (reset) begin
            m.v = 0; m.d = '0; m.s = '0; m.c = '0; m.c2 = '0;
        end else if (flush) begin
            m.v = 0; m.d = '0; m.s = '0;
        end else if (!stall) begin
            m.v = in_valid && !hz;
            if (m.v) begin
                m.d = d;
                m.s = sel;
                if (sel != 0) begin
                    if (m.c != 16'hFFFF) m.c = m.c + 1;
                    if (m.c2 != 2'b11) m.c2 = m.c2 + 1;
                end
            end
        end
        exp_q.push_back(m);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, ".queue"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            check({tag, ".valid"}, out_valid, e.v);
            check({tag, ".data"}, out_data, e.d);
            check({tag, ".src"}, out_src, e.s);
            check({tag, ".cnt"}, fwd_count, e.c);
            check({tag, ".cnt2"}, fwd_count2, e.c2);
            check({tag, ".data2"}, out_data2, e.d);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        reset = 0; in_valid = 0; in_addr = '0; rf_data = '0; src_en = '0;
        src_addr = '0; src_data = '0; src_pending = '0; stall = 0; flush = 0;
    endtask

    task automatic set_src(input int k, input logic [A-1:0] a, input logic [W-1:0] d);
        src_addr[k*A +: A] = a;
        src_data[k*W +: W] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        m = '{v: 1'b0, d: '0, s: '0, c: '0, c2: '0};
        idle();
        @(negedge clk);

        // 1: reset for two cycles, then idle
        reset = 1;
        cyc("rst0");
        cyc("rst1");
        reset = 0;
        cyc("idle");
        check("rst.cnt_lit", fwd_count, 0);

        // 2: no source enabled, register file wins
        in_valid = 1; in_addr = 5; rf_data = 32'h11; src_en = 3'b000;
        cyc("rf");
        check("rf.data_lit", out_data, 32'h11);

        // 3: two sources match, lowest index wins
        set_src(0, 5, 32'hAA); set_src(2, 5, 32'hCC); src_en = 3'b101;
        cyc("prio");
        check("prio.src_lit", out_src, 1);
        check("prio.cnt_lit", fwd_count, 1);

        // 4: register 0 is never forwarded
        idle(); in_valid = 1; in_addr = 0; set_src(0, 0, 32'hFF); src_en = 3'b001;
        cyc("zero");

        // 5: load-use hazard on the winner, then released
        idle(); in_valid = 1; in_addr = 7; rf_data = 32'h77;
        set_src(0, 7, 32'h1234); set_src(1, 7, 32'h5678); src_en = 3'b011; src_pending = 3'b001;
        cyc("haz");
        check("haz.valid_lit", out_valid, 0);
        src_pending = 3'b000;
        cyc("haz_rel");
        // pending lower-priority source is ignored
        src_pending = 3'b010;
        cyc("haz_lowpend");

        // 6: capture, stall 3 cycles, flush while stalled
        idle(); in_valid = 1; in_addr = 3; set_src(1, 3, 32'hBEEF); src_en = 3'b010;
        cyc("cap");
        stall = 1; set_src(1, 3, 32'hDEAD);
        cyc("stl0"); cyc("stl1"); cyc("stl2");
        flush = 1;
        cyc("flush");
        check("flush.data_lit", out_data, 0);
        flush = 0; stall = 0;
        cyc("post");
        check("sat.cnt2_lit", fwd_count2, 2'b11);

        // reset wins over stall and hazard
        reset = 1; stall = 1; src_pending = 3'b010;
        cyc("rst_mid");
        reset = 0; stall = 0; src_pending = '0;

        // random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid    = $urandom_range(0, 3) != 0;
            in_addr     = A'($urandom_range(0, 3));
            rf_data     = $urandom;
            src_en      = N'($urandom);
            src_pending = N'($urandom_range(0, 7)) & N'($urandom);
            for (int k = 0; k < N; k++) set_src(k, A'($urandom_range(0, 3)), $urandom);
            stall = $urandom_range(0, 7) == 0;
            flush = $urandom_range(0, 15) == 0;
            reset = $urandom_range(0, 63) == 0;
            cyc("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
